prim_stack: RTL

- Parametrised data/return stack unit for the next Prim core generation.
- Holds top (T) and second (N) in registers; deeper entries are held in a register-array spill memory.
- Executes one stack-shuffle op per cycle. Adds depth tracking, full/empty flags and sticky overflow/underflow/illegal-op detection, which the current core lacks.
- One instance serves as the data stack and one as the return stack.

---
 rtl/prim_pkg.sv | 49 ++++
 rtl/prim_stack_mem.sv | 29 ++
 rtl/prim_stack.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/prim_pkg.sv
// Shared opcode constants and decode helpers for the Prim stack unit.
package prim_pkg;

    typedef logic [3:0] stk_op_t;

    localparam stk_op_t STK_NOP     = 4'd0;
    localparam stk_op_t STK_PUSH    = 4'd1;
    localparam stk_op_t STK_DROP    = 4'd2;
    localparam stk_op_t STK_REPLACE = 4'd3;
    localparam stk_op_t STK_BINOP   = 4'd4;
    localparam stk_op_t STK_SWAP    = 4'd5;
    localparam stk_op_t STK_OVER    = 4'd6;
    localparam stk_op_t STK_DUP     = 4'd7;
    localparam stk_op_t STK_NIP     = 4'd8;
    localparam stk_op_t STK_ROT     = 4'd9;
    localparam stk_op_t STK_NROT    = 4'd10;
    localparam stk_op_t STK_DROP2   = 4'd11;

    // Net change in depth an op causes when it executes.
    typedef enum logic [1:0] {
        StkKeep,
        StkPush,
        StkPop,
        StkPop2
    } stk_class_e;

    function automatic logic [1:0] stk_min_depth(input stk_op_t op);
        case (op)
            STK_DROP, STK_REPLACE, STK_DUP:                       return 2'd1;
            STK_BINOP, STK_SWAP, STK_OVER, STK_NIP, STK_DROP2:    return 2'd2;
            STK_ROT, STK_NROT:                                    return 2'd3;
            default:                                              return 2'd0;
        endcase
    endfunction

    function automatic stk_class_e stk_class(input stk_op_t op);
        case (op)
            STK_PUSH, STK_OVER, STK_DUP:   return StkPush;
            STK_DROP, STK_BINOP, STK_NIP:  return StkPop;
            STK_DROP2:                     return StkPop2;
            default:                       return StkKeep;
        endcase
    endfunction

    function automatic logic stk_reserved(input stk_op_t op);
        return op > STK_DROP2;
    endfunction

endpackage

// File: rtl/prim_stack_mem.sv
// Spill memory: register array with one synchronous write port and
// combinational reads at the pointer and the entry below it.
module prim_stack_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SSZ   = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [SSZ-1:0]   i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [SSZ-1:0]   i_ptr,
    output logic [WIDTH-1:0] o_rd_top,
    output logic [WIDTH-1:0] o_rd_below
);

    logic [WIDTH-1:0] r_mem [2**SSZ];
    logic [SSZ-1:0]   w_ptr_m1;

    assign w_ptr_m1   = i_ptr - 1'b1;
    assign o_rd_top   = r_mem[i_ptr];
    assign o_rd_below = r_mem[w_ptr_m1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/prim_stack.sv
// Data/return stack: T and N in registers, deeper entries spilled to a
// register array, with depth tracking and sticky fault flags.
module prim_stack
    import prim_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SSZ   = 4,
    parameter int unsigned DW    = SSZ + 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_t,
    output logic [WIDTH-1:0] o_n,
    output logic [WIDTH-1:0] o_third,
    output logic [DW-1:0]    o_depth,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_illegal
);

    localparam logic [DW-1:0] CAP = DW'((2 ** SSZ) + 2);
    localparam logic [DW-1:0] D1  = DW'(1);
    localparam logic [DW-1:0] D2  = DW'(2);
    localparam logic [DW-1:0] D3  = DW'(3);
    localparam logic [DW-1:0] D4  = DW'(4);

    logic [WIDTH-1:0] r_t, r_n;
    logic [DW-1:0]    r_depth;
    logic [SSZ-1:0]   r_sp;
    logic             r_ovf, r_unf, r_ill;

    logic [WIDTH-1:0] w_t_d, w_n_d, w_wdata;
    logic [WIDTH-1:0] w_rd_top, w_rd_below, w_third, w_below;
    logic [DW-1:0]    w_depth_d, w_cnt, w_cnt_d;
    logic [SSZ-1:0]   w_sp_d, w_waddr;
    logic             w_we, w_fault_ill, w_fault_unf, w_fault_ovf, w_exec;
    stk_class_e       w_class;

    prim_stack_mem #(
        .WIDTH (WIDTH),
        .SSZ   (SSZ)
    ) u_mem (
        .i_clk      (i_clk),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_ptr      (r_sp),
        .o_rd_top   (w_rd_top),
        .o_rd_below (w_rd_below)
    );

    assign w_class     = stk_class(i_op);
    assign w_fault_ill = stk_reserved(i_op);
    assign w_fault_unf = !w_fault_ill && (r_depth < DW'(stk_min_depth(i_op)));
    assign w_fault_ovf = !w_fault_ill && !w_fault_unf && (w_class == StkPush) && o_full;
    assign w_exec      = (i_op != STK_NOP) && !w_fault_ill && !w_fault_unf && !w_fault_ovf;

    // Entries held in the spill memory; r_sp addresses the topmost one.
    assign w_cnt   = (r_depth >= D2) ? r_depth - D2 : '0;
    assign w_third = (r_depth >= D3) ? w_rd_top : '0;
    assign w_below = (r_depth >= D4) ? w_rd_below : '0;

    always_comb begin
        w_t_d     = r_t;
        w_n_d     = r_n;
        w_depth_d = r_depth;
        w_cnt_d   = w_cnt;
        w_sp_d    = r_sp;
        w_we      = 1'b0;
        w_waddr   = r_sp;
        w_wdata   = r_n;
        if (w_exec) begin
            unique case (i_op)
                STK_PUSH:    begin w_t_d = i_dat; w_n_d = r_t;     end
                STK_DROP:    begin w_t_d = r_n;   w_n_d = w_third; end
                STK_REPLACE: begin w_t_d = i_dat;                  end
                STK_BINOP:   begin w_t_d = i_dat; w_n_d = w_third; end
                STK_SWAP:    begin w_t_d = r_n;   w_n_d = r_t;     end
                STK_OVER:    begin w_t_d = r_n;   w_n_d = r_t;     end
                STK_DUP:     begin                w_n_d = r_t;     end
                STK_NIP:     begin                w_n_d = w_third; end
                STK_ROT: begin
                    w_t_d = w_third;
                    w_n_d = r_t;
                    w_we  = 1'b1;
                end
                STK_NROT: begin
                    w_t_d   = r_n;
                    w_n_d   = w_third;
                    w_we    = 1'b1;
                    w_wdata = r_t;
                end
                STK_DROP2:   begin w_t_d = w_third; w_n_d = w_below; end
                default: ;
            endcase

            case (w_class)
                StkPush: begin
                    w_depth_d = r_depth + D1;
                    if (r_depth >= D2) begin
                        w_we    = 1'b1;
                        w_waddr = (w_cnt == '0) ? '0 : r_sp + 1'b1;
                        w_cnt_d = w_cnt + D1;
                    end
                end
                StkPop: begin
                    w_depth_d = r_depth - D1;
                    w_cnt_d   = (w_cnt != '0) ? w_cnt - D1 : '0;
                end
                StkPop2: begin
                    w_depth_d = r_depth - D2;
                    w_cnt_d   = (w_cnt >= D2) ? w_cnt - D2 : '0;
                end
                default: ;
            endcase
            w_sp_d = (w_cnt_d == '0) ? '0 : SSZ'(w_cnt_d - D1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_t     <= '0;
            r_n     <= '0;
            r_depth <= '0;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_t     <= w_t_d;
            r_n     <= w_n_d;
            r_depth <= w_depth_d;
            r_sp    <= w_sp_d;
            // A fault in the same cycle as a clear leaves its flag set.
            r_ovf   <= w_fault_ovf | (r_ovf & ~i_clr_err);
            r_unf   <= w_fault_unf | (r_unf & ~i_clr_err);
            r_ill   <= w_fault_ill | (r_ill & ~i_clr_err);
        end
    end

    assign o_t         = (r_depth >= D1) ? r_t : '0;
    assign o_n         = (r_depth >= D2) ? r_n : '0;
    assign o_third     = w_third;
    assign o_depth     = r_depth;
    assign o_empty     = (r_depth == '0);
    assign o_full      = (r_depth == CAP);
    assign o_overflow  = r_ovf;
    assign o_underflow = r_unf;
    assign o_illegal   = r_ill;

endmodule
